// File: rtl/matmul_pkg.sv
// Shared types and widths for the matrix-multiply controller and its index generator.
package matmul_pkg;

    localparam int OP_W  = 8;
    localparam int ACC_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/matmul_index_gen.sv
// Nested i/j/k loop counters: k walks the dot product, j then i walk the output element.
module matmul_index_gen #(
    parameter int DIM = 4,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          step_k,
    input  logic          step_ij,
    output logic [CW-1:0] i,
    output logic [CW-1:0] j,
    output logic [CW-1:0] k,
    output logic          k_last,
    output logic          ij_last
);

    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    assign k_last  = (k == LAST);
    assign ij_last = (i == LAST) && (j == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (step_k) begin
                k <= k_last ? '0 : k + 1'b1;
            end
            if (step_ij) begin
                if (j == LAST) begin
                    j <= '0;
                    i <= (i == LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_controller.sv
// Sequences an external signed MAC over row-major A/B memories to produce C = A x B.
module matmul_controller
    import matmul_pkg::*;
#(
    parameter int DIM = 4,
    parameter int AW  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    a_addr,
    output logic [AW-1:0]    b_addr,
    output logic             rd_en,
    input  logic [OP_W-1:0]  a_rdata,
    input  logic [OP_W-1:0]  b_rdata,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_enable,
    output logic             mac_start,
    input  logic [ACC_W-1:0] mac_acc,
    output logic [AW-1:0]    c_addr,
    output logic [ACC_W-1:0] c_data,
    output logic             c_we
);

    localparam logic [AW-1:0] DIM_W = AW'(DIM);

    state_t        state;
    logic          issue_v;
    logic          issue_first;
    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [AW-1:0] k;
    logic          k_last;
    logic          ij_last;
    logic          clr;
    logic          step_k;
    logic          step_ij;

    assign clr     = (state == ST_IDLE) && start;
    assign step_k  = (state == ST_ISSUE);
    assign step_ij = (state == ST_WRITE);

    matmul_index_gen #(
        .DIM (DIM),
        .CW  (AW)
    ) u_index_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .step_k  (step_k),
        .step_ij (step_ij),
        .i       (i),
        .j       (j),
        .k       (k),
        .k_last  (k_last),
        .ij_last (ij_last)
    );

    assign a_addr = i * DIM_W + k;
    assign b_addr = k * DIM_W + j;
    assign c_addr = i * DIM_W + j;

    assign mac_a      = a_rdata;
    assign mac_b      = b_rdata;
    assign mac_enable = issue_v;
    assign mac_start  = issue_first;
    assign c_data     = mac_acc;

    // Outputs are registered alongside the state, so each branch sets them for the state it enters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            c_we        <= 1'b0;
            issue_v     <= 1'b0;
            issue_first <= 1'b0;
        end else begin
            issue_v     <= (state == ST_ISSUE);
            issue_first <= (state == ST_ISSUE) && (k == '0);
            done        <= 1'b0;
            c_we        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (k_last) begin
                        state <= ST_WAIT;
                        rd_en <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    state <= ST_WRITE;
                    c_we  <= 1'b1;
                end
                ST_WRITE: begin
                    if (ij_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_ISSUE;
                        rd_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
